// File: rtl/alu_rr_pkg.sv
// Shared types and encodings for the R-type ALU sequencer.
package alu_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT      = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  localparam logic [6:0] FUNCT7_BASE    = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT     = 7'b0100000;
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;

endpackage

// File: rtl/alu_rr_legal_check.sv
// Combinational legality decode of an R-type funct7/funct3 pair.
module alu_rr_legal_check
  import alu_rr_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    if (funct7 == FUNCT7_BASE) begin
      legal = 1'b1;
    end else if (funct7 == FUNCT7_ALT &&
                 (funct3 == FUNCT3_ADD_SUB || funct3 == FUNCT3_SRL_SRA)) begin
      legal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Issues one R-type op to the external ALU, waits its latency, and hands the
// result to register-file writeback.
//
// state        | meaning
// -------------+--------------------------------------------------------
// ST_IDLE      | ready for a new op; illegal ops are rejected here
// ST_ISSUE     | alu_enable high for one cycle, wait counter loaded
// ST_WAIT      | counting down ALU latency; result captured at count 1
// ST_WRITEBACK | wb_valid high until the register file takes it
module alu_rr_sequencer
  import alu_rr_pkg::*;
#(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [4:0]  in_rd,
  output logic        alu_enable,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_operand_0,
  output logic [31:0] alu_operand_1,
  input  logic [31:0] alu_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal_instr,
  output logic        busy,
  output logic [31:0] retired_count
);

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY);

  state_t      state;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic [4:0]  rd_q;
  logic [31:0] wb_data_q;
  logic [3:0]  wait_cnt;
  logic [31:0] retired_q;
  logic        illegal_q;
  logic        legal;

  alu_rr_legal_check u_legal (
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .legal  (legal)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wb_data_q <= '0;
      wait_cnt  <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            funct3_q <= in_funct3;
            funct7_q <= in_funct7;
            rs1_q    <= in_rs1_data;
            rs2_q    <= in_rs2_data;
            rd_q     <= in_rd;
            if (legal) state <= ST_ISSUE;
            else       illegal_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          wait_cnt <= LAT_LOAD;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            wb_data_q <= alu_result;
            // Writes to x0 retire without a writeback request.
            if (rd_q != 5'd0) begin
              state <= ST_WRITEBACK;
            end else begin
              state     <= ST_IDLE;
              retired_q <= retired_q + 32'd1;
            end
          end
        end
        ST_WRITEBACK: begin
          if (wb_ready) begin
            state     <= ST_IDLE;
            retired_q <= retired_q + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign alu_enable    = (state == ST_ISSUE);
  assign wb_valid      = (state == ST_WRITEBACK);
  assign alu_funct3    = funct3_q;
  assign alu_funct7    = funct7_q;
  assign alu_operand_0 = rs1_q;
  assign alu_operand_1 = rs2_q;
  assign wb_rd         = rd_q;
  assign wb_data       = wb_data_q;
  assign illegal_instr = illegal_q;
  assign retired_count = retired_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Scoreboard bench: two sequencers (ALU latency 1 and 3) with behavioural ALU models.
module tb_alu_rr_sequencer;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset1, reset3;
  logic        in_valid1, in_valid3;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_rs1, in_rs2;
  logic [4:0]  in_rd;
  logic        wb_ready1, wb_ready3;

  logic        in_ready1, alu_en1, wb_valid1, illegal1, busy1;
  logic [2:0]  alu_f3_1;
  logic [6:0]  alu_f7_1;
  logic [31:0] alu_op0_1, alu_op1_1, alu_res1, wb_data1, retired1;
  logic [4:0]  wb_rd1;

  logic        in_ready3, alu_en3, wb_valid3, illegal3, busy3;
  logic [2:0]  alu_f3_3;
  logic [6:0]  alu_f7_3;
  logic [31:0] alu_op0_3, alu_op1_3, alu_res3, wb_data3, retired3;
  logic [4:0]  wb_rd3;

  alu_rr_sequencer #(.ALU_LATENCY(1)) u1 (
    .clock(clock), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rs1_data(in_rs1),
    .in_rs2_data(in_rs2), .in_rd(in_rd), .alu_enable(alu_en1),
    .alu_funct3(alu_f3_1), .alu_funct7(alu_f7_1), .alu_operand_0(alu_op0_1),
    .alu_operand_1(alu_op1_1), .alu_result(alu_res1), .wb_valid(wb_valid1),
    .wb_ready(wb_ready1), .wb_rd(wb_rd1), .wb_data(wb_data1),
    .illegal_instr(illegal1), .busy(busy1), .retired_count(retired1)
  );

  alu_rr_sequencer #(.ALU_LATENCY(3)) u3 (
    .clock(clock), .reset(reset3), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_rs1_data(in_rs1),
    .in_rs2_data(in_rs2), .in_rd(in_rd), .alu_enable(alu_en3),
    .alu_funct3(alu_f3_3), .alu_funct7(alu_f7_3), .alu_operand_0(alu_op0_3),
    .alu_operand_1(alu_op1_3), .alu_result(alu_res3), .wb_valid(wb_valid3),
    .wb_ready(wb_ready3), .wb_rd(wb_rd3), .wb_data(wb_data3),
    .illegal_instr(illegal3), .busy(busy3), .retired_count(retired3)
  );

  // RV32I R-type ALU; result is poisoned outside its valid window.
  function automatic logic [31:0] alu_fn(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu_fn = f7[5] ? a - b : a + b;
      3'b001:  alu_fn = a << b[4:0];
      3'b010:  alu_fn = {31'b0, $signed(a) < $signed(b)};
      3'b011:  alu_fn = {31'b0, a < b};
      3'b100:  alu_fn = a ^ b;
      3'b101:  alu_fn = f7[5] ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu_fn = a | b;
      default: alu_fn = a & b;
    endcase
  endfunction

  localparam logic [31:0] POISON = 32'hBAD0_BAD0;
  logic [31:0] p3_0, p3_1, p3_2;

  always @(posedge clock) begin
    alu_res1 <= alu_en1 ? alu_fn(alu_f3_1, alu_f7_1, alu_op0_1, alu_op1_1) : POISON;
    p3_0     <= alu_en3 ? alu_fn(alu_f3_3, alu_f7_3, alu_op0_3, alu_op1_3) : POISON;
    p3_1     <= p3_0;
    p3_2     <= p3_1;
  end
  assign alu_res3 = p3_2;

  int tests = 0;
  int failed = 0;
  wb_t q1[$];
  wb_t q3[$];
  logic [31:0] exp_ret1 = '0;
  logic [31:0] exp_ret3 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every accepted writeback must match the head of its queue.
  always @(negedge clock) begin
    wb_t e;
    if (!reset1 && wb_valid1 && wb_ready1) begin
      if (q1.size() == 0) chk("wb1_unexpected", 32'(wb_rd1), 32'hFFFF_FFFF);
      else begin
        e = q1.pop_front();
        chk("wb1_rd", 32'(wb_rd1), 32'(e.rd));
        chk("wb1_data", wb_data1, e.data);
      end
    end
    if (!reset3 && wb_valid3 && wb_ready3) begin
      if (q3.size() == 0) chk("wb3_unexpected", 32'(wb_rd3), 32'hFFFF_FFFF);
      else begin
        e = q3.pop_front();
        chk("wb3_rd", 32'(wb_rd3), 32'(e.rd));
        chk("wb3_data", wb_data3, e.data);
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    in_funct3 = f3; in_funct7 = f7; in_rs1 = a; in_rs2 = b; in_rd = rd;
  endtask

  task automatic op1(input string name, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                     input logic [31:0] exp, input int stall);
    int first = 0;
    int en = 0;
    bit done = 0;
    logic [4:0] hrd;
    logic [31:0] hdata;
    if (rd != 5'd0) q1.push_back('{rd: rd, data: exp});
    @(posedge clock); #1;
    drive(f3, f7, a, b, rd);
    wb_ready1 = (stall == 0);
    in_valid1 = 1'b1;
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clock);
      if (alu_en1) en++;
      if (wb_valid1 && first == 0) begin
        first = c;
        hrd = wb_rd1;
        hdata = wb_data1;
        if (stall > 0) begin
          for (int s = 0; s < stall; s++) begin
            @(negedge clock);
            chk({name, "_stall_valid"}, 32'(wb_valid1), 32'd1);
            chk({name, "_stall_rd"}, 32'(wb_rd1), 32'(hrd));
            chk({name, "_stall_data"}, wb_data1, hdata);
          end
          @(posedge clock); #1;
          wb_ready1 = 1'b1;
        end
      end
      if (c > 1 && !busy1) done = 1;
    end
    exp_ret1 = exp_ret1 + 32'd1;
    chk({name, "_enable_cycles"}, 32'(en), 32'd1);
    chk({name, "_wb_cycle"}, 32'(first), (rd != 5'd0) ? 32'd3 : 32'd0);
    chk({name, "_idle"}, 32'(busy1), 32'd0);
    chk({name, "_retired"}, retired1, exp_ret1);
  endtask

  task automatic op3(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] exp);
    int first = 0;
    bit done = 0;
    q3.push_back('{rd: rd, data: exp});
    @(posedge clock); #1;
    drive(3'b000, 7'b0000000, a, b, rd);
    in_valid3 = 1'b1;
    @(posedge clock); #1;
    in_valid3 = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clock);
      if (wb_valid3 && first == 0) first = c;
      if (c > 1 && !busy3) done = 1;
    end
    exp_ret3 = exp_ret3 + 32'd1;
    chk({name, "_wb_cycle"}, 32'(first), 32'd5);
    chk({name, "_retired"}, retired3, exp_ret3);
  endtask

  task automatic illegal_one(input string name, input logic [2:0] f3, input logic [6:0] f7);
    @(posedge clock); #1;
    drive(f3, f7, 32'd9, 32'd9, 5'd4);
    in_valid1 = 1'b1;
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    @(negedge clock);
    chk({name, "_pulse"}, 32'(illegal1), 32'd1);
    chk({name, "_in_ready"}, 32'(in_ready1), 32'd1);
    chk({name, "_no_enable"}, 32'(alu_en1 | busy1), 32'd0);
    @(negedge clock);
    chk({name, "_pulse_end"}, 32'(illegal1), 32'd0);
    chk({name, "_no_enable2"}, 32'(alu_en1 | busy1), 32'd0);
    chk({name, "_retired"}, retired1, exp_ret1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset1 = 1'b1; reset3 = 1'b1;
    in_valid1 = 1'b0; in_valid3 = 1'b0;
    wb_ready1 = 1'b1; wb_ready3 = 1'b1;
    drive(3'b000, 7'b0000000, '0, '0, '0);
    repeat (3) @(posedge clock);
    #1;
    reset1 = 1'b0; reset3 = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 32'(in_ready1), 32'd1);
    chk("rst_ctrl", 32'({alu_en1, wb_valid1, illegal1, busy1}), 32'd0);
    chk("rst_alu_funct", 32'({alu_f3_1, alu_f7_1}), 32'd0);
    chk("rst_op0", alu_op0_1, 32'd0);
    chk("rst_op1", alu_op1_1, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd1), 32'd0);
    chk("rst_wb_data", wb_data1, 32'd0);
    chk("rst_retired", retired1, 32'd0);

    op1("add", 3'b000, 7'b0000000, 32'd5, 32'd7, 5'd3, 32'd12, 0);
    op1("sub_stall", 3'b000, 7'b0100000, 32'd0, 32'd1, 5'd5, 32'hFFFF_FFFF, 5);
    illegal_one("ill_f3_001", 3'b001, 7'b0100000);
    illegal_one("ill_mext", 3'b000, 7'b0000001);
    op1("rd0", 3'b000, 7'b0000000, 32'd1, 32'd1, 5'd0, 32'd2, 0);
    op1("sra", 3'b101, 7'b0100000, 32'h8000_0000, 32'd4, 5'd7, 32'hF800_0000, 0);
    op1("or", 3'b110, 7'b0000000, 32'h0F0F_0000, 32'h00F0_F00F, 5'd31, 32'h0FFF_F00F, 0);
    op1("sltu", 3'b011, 7'b0000000, 32'd1, 32'hFFFF_FFFF, 5'd1, 32'd1, 0);

    // Back-to-back illegal ops each produce their own pulse.
    @(posedge clock); #1;
    drive(3'b111, 7'b0100000, 32'd1, 32'd2, 5'd2);
    in_valid1 = 1'b1;
    @(posedge clock); #1;
    drive(3'b010, 7'b0000001, 32'd1, 32'd2, 5'd2);
    @(negedge clock);
    chk("b2b_pulse1", 32'(illegal1), 32'd1);
    chk("b2b_ready", 32'(in_ready1), 32'd1);
    @(posedge clock); #1;
    in_valid1 = 1'b0;
    @(negedge clock);
    chk("b2b_pulse2", 32'(illegal1), 32'd1);
    @(negedge clock);
    chk("b2b_end", 32'({illegal1, alu_en1, busy1}), 32'd0);
    chk("b2b_retired", retired1, exp_ret1);

    // Latency-3 instance: normal op, reset during WAIT, then normal op again.
    op3("l3_first", 32'd10, 32'd20, 5'd6, 32'd30);
    @(posedge clock); #1;
    drive(3'b000, 7'b0000000, 32'd2, 32'd3, 5'd4);
    in_valid3 = 1'b1;
    @(posedge clock); #1;
    in_valid3 = 1'b0;
    @(negedge clock);
    chk("l3_issue", 32'(alu_en3), 32'd1);
    @(posedge clock); #1;
    reset3 = 1'b1;
    @(posedge clock); #1;
    reset3 = 1'b0;
    @(negedge clock);
    chk("l3_rst_idle", 32'({in_ready3, busy3, wb_valid3}), 32'b100);
    chk("l3_rst_retired", retired3, 32'd0);
    exp_ret3 = '0;
    repeat (4) @(negedge clock);
    chk("l3_rst_no_wb", 32'({wb_valid3, busy3}), 32'd0);
    op3("l3_after", 32'd100, 32'd23, 5'd8, 32'd123);

    // Counter wrap.
    @(posedge clock); #1;
    force u1.retired_q = 32'hFFFF_FFFF;
    #1;
    release u1.retired_q;
    @(negedge clock);
    chk("wrap_preload", retired1, 32'hFFFF_FFFF);
    exp_ret1 = 32'hFFFF_FFFF;
    op1("wrap", 3'b000, 7'b0000000, 32'd2, 32'd2, 5'd9, 32'd4, 0);
    chk("wrap_zero", retired1, 32'd0);

    repeat (3) @(negedge clock);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/alu_rr_sequencer.md
# alu_rr_sequencer

Sequencer for the register-register (R-type) ALU of the RV32I core. It accepts one decoded R-type operation at a time over a valid/ready handshake and rejects illegal funct7/funct3 combinations. It drives the ALU's enable, funct and operand inputs for exactly one issue cycle, waits the ALU's fixed latency, and captures the result. It then presents the result to register-file writeback over a second valid/ready handshake, suppressing writes to x0. It sits between instruction decode and the `alu_register_register` datapath.

## Interface
Parameters:
- `ALU_LATENCY`, default 1: cycles from the issue-cycle clock edge to a valid `alu_result`. Legal range is 1..15.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: decode presents an operation.
- `in_ready`  out  1: sequencer can accept an operation.
- `in_funct3`  in  3: operation funct3.
- `in_funct7`  in  7: operation funct7.
- `in_rs1_data`  in  32: first operand.
- `in_rs2_data`  in  32: second operand.
- `in_rd`  in  5: destination register index.
- `alu_enable`  out  1: ALU enable, high only in the ISSUE state.
- `alu_funct3`  out  3: funct3 to the ALU.
- `alu_funct7`  out  7: funct7 to the ALU.
- `alu_operand_0`  out  32: first operand to the ALU.
- `alu_operand_1`  out  32: second operand to the ALU.
- `alu_result`  in  32: ALU destination output.
- `wb_valid`  out  1: writeback request.
- `wb_ready`  in  1: register file accepts the writeback.
- `wb_rd`  out  5: writeback destination index.
- `wb_data`  out  32: writeback data.
- `illegal_instr`  out  1: one-cycle pulse when an accepted operation is illegal.
- `busy`  out  1: high in any state other than IDLE.
- `retired_count`  out  32: count of completed legal operations; wraps.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITEBACK.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`, latch funct3, funct7, rs1, rs2 and rd into holding registers.
  - Legal operation: go to ISSUE.
  - Illegal operation: stay in IDLE and assert `illegal_instr` for the next cycle only.
- **Legality rules**
  - Legal if funct7=0000000 with any funct3.
  - Legal if funct7=0100000 with funct3=000 (SUB) or funct3=101 (SRA).
  - All other combinations are illegal.
- **ISSUE** (exactly 1 cycle)
  - `alu_enable`=1.
  - Load the wait counter with `ALU_LATENCY`.
  - Go to WAIT.
- **WAIT**
  - Decrement the wait counter every cycle.
  - When the counter reaches 1, capture `alu_result` into the `wb_data` register at that edge.
  - rd≠0: go to WRITEBACK.
  - rd=0: go to IDLE and increment `retired_count`. No writeback is issued.
- **WRITEBACK**
  - `wb_valid`=1. `wb_rd` and `wb_data` are held stable until `wb_ready`.
  - On `wb_valid && wb_ready`: go to IDLE and increment `retired_count`.
- **ALU output hold:** `alu_funct3`, `alu_funct7`, `alu_operand_0` and `alu_operand_1` are driven from the holding registers. They stay stable from ISSUE through the capture edge.
- **Counter:** `retired_count` is a 32-bit counter; 0xFFFFFFFF + 1 wraps to 0.

## Timing
- **Reset values:**
  - FSM returns to IDLE. `in_ready`=1 in the first cycle after reset.
  - `alu_enable`, `wb_valid`, `illegal_instr` and `busy` are 0.
  - `alu_funct3`, `alu_funct7`, `alu_operand_0`, `alu_operand_1`, `wb_rd`, `wb_data` and `retired_count` are 0.
- **Accept-to-writeback latency:**
  - Accept at edge E.
  - ISSUE occupies cycle E+1.
  - WAIT occupies cycles E+2 .. E+1+`ALU_LATENCY`.
  - `wb_valid` rises in cycle E+2+`ALU_LATENCY`.
- **Throughput:** minimum one operation per 3+`ALU_LATENCY` cycles. `in_ready` is 0 in every non-IDLE state; there is no overlap.
- **Ready and illegal pulses:**
  - `in_ready` is a pure function of state. It does not depend combinationally on `in_valid`.
  - `in_ready` stays 1 in the cycle after an illegal rejection, so back-to-back illegal operations each produce a pulse.
- **Writeback stall:** if `wb_ready` is held low indefinitely, the FSM stays in WRITEBACK with no data change.
- **Reset mid-operation:** a reset in any state discards the in-flight operation. No writeback occurs and `retired_count` is cleared.
- **Retired increment:** the retired counter increments in the same edge as the WRITEBACK→IDLE or WAIT→IDLE transition.

## Structure
- **Package `alu_rr_pkg`:**
  - State encoding enum.
  - `FUNCT7_BASE`=7'b0000000 and `FUNCT7_ALT`=7'b0100000.
  - `FUNCT3_ADD_SUB`=3'b000 and `FUNCT3_SRL_SRA`=3'b101.
- **Sub-module:** `alu_rr_legal_check`, a combinational funct7/funct3 legality decode. Its output `legal` is used in IDLE.
- **ALU:** the `alu_register_register` instance is external. This block drives its ports.

## Test plan
- Reset, then ADD (funct7=0, funct3=000, rs1=5, rs2=7, rd=3), ALU model `ALU_LATENCY`=1, `wb_ready`=1 → `alu_enable` high for one cycle; `wb_valid` in cycle E+3 with `wb_rd`=3 and `wb_data`=12; `retired_count`=1.
- SUB with funct7=0100000, rs1=0, rs2=1 → `wb_data`=0xFFFFFFFF; hold `wb_ready`=0 for 5 cycles → `wb_valid`, `wb_rd` and `wb_data` are stable throughout; single transfer on release.
- Illegal funct7=0100000 with funct3=001 → `illegal_instr` pulses once, no `alu_enable`, `in_ready` stays 1, `retired_count` unchanged.
- rd=0 with ADD of 1+1 → `alu_enable` pulses, `wb_valid` never asserts, `retired_count` increments, FSM returns to IDLE.
- `ALU_LATENCY`=3, assert `reset` during WAIT → next cycle: IDLE, `busy`=0, `wb_valid`=0, `retired_count`=0; a following operation completes normally with `wb_valid` at E+5.
- Preload `retired_count` to 0xFFFFFFFF via 2^32−1 fast-forwarded operations (force) then retire one more → `retired_count`=0.
